word_gen_reader: RTL

- Consumer end of the word generator's 8-bit output storage.
- Reads one candidate byte per cycle through `rd_addr`, assembles it into a `WORD_MAX_LEN`-byte wide word, releases the storage with `set_empty`, and presents the word with its IDs to the hashing core via a valid/ready handshake.
- Double-buffered: an assembly register and an output register, so reading the next candidate overlaps with the core consuming the current one.

---
 rtl/word_gen_reader_if.sv | 33 +++
 rtl/word_gen_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_gen_reader_if.sv
// Output-side interface of word_gen_reader: assembled word, its IDs and the valid/ready handshake.
// Optional macro WORD_GEN_READER_LEN_OUT_EN adds the word_len field.
interface word_gen_reader_if #(
  parameter int WORD_MAX_LEN = 8
);
  logic [WORD_MAX_LEN*8-1:0] dout;
  logic [15:0]               pkt_id;
  logic [15:0]               word_id;
  logic [31:0]               gen_id;
  logic                      gen_end;
  logic                      word_end;
  logic                      out_valid;
  logic                      out_rd_en;
`ifdef WORD_GEN_READER_LEN_OUT_EN
  logic [$clog2(WORD_MAX_LEN+1)-1:0] word_len;
`endif

  modport master (
`ifdef WORD_GEN_READER_LEN_OUT_EN
    output word_len,
`endif
    output dout, pkt_id, word_id, gen_id, gen_end, word_end, out_valid,
    input  out_rd_en
  );

  modport slave (
`ifdef WORD_GEN_READER_LEN_OUT_EN
    input  word_len,
`endif
    input  dout, pkt_id, word_id, gen_id, gen_end, word_end, out_valid,
    output out_rd_en
  );
endinterface

// File: rtl/word_gen_reader.sv
// Reads one candidate word byte-by-byte from the generator storage and presents it double-buffered.
// Optional macro WORD_GEN_READER_LEN_OUT_EN exposes the null-terminated length as word_len.
module word_gen_reader #(
  parameter int WORD_MAX_LEN = 8
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [7:0]                        din,
  output logic [$clog2(WORD_MAX_LEN)-1:0]   rd_addr,
  input  logic                              empty,
  output logic                              set_empty,
  input  logic [15:0]                       pkt_id_in,
  input  logic [15:0]                       word_id_in,
  input  logic [31:0]                       gen_id_in,
  input  logic                              gen_end_in,
  input  logic                              word_end_in,
  word_gen_reader_if.master                 out_if
);

  localparam int AW = $clog2(WORD_MAX_LEN);
  localparam int DW = WORD_MAX_LEN * 8;
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(WORD_MAX_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            set_empty_q, set_empty_d;
  logic            null_seen_q, null_seen_d;
  logic            asm_full_q, asm_full_d;
  logic [DW-1:0]   asm_data_q, asm_data_d;
  logic [15:0]     asm_pkt_q, asm_pkt_d, asm_wid_q, asm_wid_d;
  logic [31:0]     asm_gen_q, asm_gen_d;
  logic            asm_gend_q, asm_gend_d, asm_wend_q, asm_wend_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [15:0]     out_pkt_q, out_pkt_d, out_wid_q, out_wid_d;
  logic [31:0]     out_gen_q, out_gen_d;
  logic            out_gend_q, out_gend_d, out_wend_q, out_wend_d;

  logic            xfer_s, hold_s, start_s, cap_en_s, is_nul_s;
  logic [AW-1:0]   cap_idx_s;
  logic [7:0]      cap_byte_s;

`ifdef WORD_GEN_READER_LEN_OUT_EN
  localparam int LW = $clog2(WORD_MAX_LEN + 1);
  logic [LW-1:0]   asm_len_q, asm_len_d, out_len_q, out_len_d;
`endif

  // A terminal (gen_end) word entering or sitting unconsumed in the output register blocks new reads.
  assign xfer_s  = asm_full_q & (~out_valid_q | out_if.out_rd_en);
  assign hold_s  = xfer_s ? asm_gend_q : (out_valid_q & out_gend_q & ~out_if.out_rd_en);
  assign start_s = ~empty & (~asm_full_q | xfer_s) & ~hold_s;

  assign cap_en_s   = (state_q == READ) || (state_q == LAST);
  assign cap_idx_s  = (state_q == LAST) ? ADDR_LAST : (rd_addr_q - ADDR_ONE);
  assign is_nul_s   = (din == 8'h00);
  assign cap_byte_s = (null_seen_q | is_nul_s) ? 8'h00 : din;

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_s ? READ : IDLE;
      READ:    state_d = (rd_addr_q == ADDR_LAST) ? LAST : READ;
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    rd_addr_d   = rd_addr_q;
    null_seen_d = null_seen_q;
    asm_full_d  = asm_full_q;
    asm_data_d  = asm_data_q;
    asm_pkt_d   = asm_pkt_q;
    asm_wid_d   = asm_wid_q;
    asm_gen_d   = asm_gen_q;
    asm_gend_d  = asm_gend_q;
    asm_wend_d  = asm_wend_q;
`ifdef WORD_GEN_READER_LEN_OUT_EN
    asm_len_d   = asm_len_q;
`endif
    set_empty_d = (state_d == LAST);

    case (state_q)
      IDLE:    rd_addr_d = start_s ? ADDR_ONE : {AW{1'b0}};
      READ:    rd_addr_d = (rd_addr_q == ADDR_LAST) ? {AW{1'b0}} : (rd_addr_q + ADDR_ONE);
      LAST:    rd_addr_d = {AW{1'b0}};
      default: rd_addr_d = {AW{1'b0}};
    endcase

    if ((state_q == IDLE) && start_s) begin
      null_seen_d = 1'b0;
      asm_pkt_d   = pkt_id_in;
      asm_wid_d   = word_id_in;
      asm_gen_d   = gen_id_in;
      asm_gend_d  = gen_end_in;
      asm_wend_d  = word_end_in;
`ifdef WORD_GEN_READER_LEN_OUT_EN
      asm_len_d   = LW'(WORD_MAX_LEN);
`endif
    end else if (cap_en_s) begin
      for (int i = 0; i < WORD_MAX_LEN; i++) begin
        if (AW'(i) == cap_idx_s) begin
          asm_data_d[i*8 +: 8] = cap_byte_s;
        end else begin
          asm_data_d[i*8 +: 8] = asm_data_q[i*8 +: 8];
        end
      end
      null_seen_d = null_seen_q | is_nul_s;
`ifdef WORD_GEN_READER_LEN_OUT_EN
      if (is_nul_s && !null_seen_q) begin
        asm_len_d = LW'(cap_idx_s);
      end else begin
        asm_len_d = asm_len_q;
      end
`endif
    end else begin
      null_seen_d = null_seen_q;
    end

    if (state_q == LAST) begin
      asm_full_d = 1'b1;
    end else if (xfer_s) begin
      asm_full_d = 1'b0;
    end else begin
      asm_full_d = asm_full_q;
    end
  end

  // Output register next values: refill on transfer, otherwise drop valid on consume
  always_comb begin
    out_data_d  = out_data_q;
    out_pkt_d   = out_pkt_q;
    out_wid_d   = out_wid_q;
    out_gen_d   = out_gen_q;
    out_gend_d  = out_gend_q;
    out_wend_d  = out_wend_q;
`ifdef WORD_GEN_READER_LEN_OUT_EN
    out_len_d   = out_len_q;
`endif
    out_valid_d = out_valid_q & ~out_if.out_rd_en;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = asm_data_q;
      out_pkt_d   = asm_pkt_q;
      out_wid_d   = asm_wid_q;
      out_gen_d   = asm_gen_q;
      out_gend_d  = asm_gend_q;
      out_wend_d  = asm_wend_q;
`ifdef WORD_GEN_READER_LEN_OUT_EN
      out_len_d   = asm_len_q;
`endif
    end else begin
      out_data_d  = out_data_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_addr_q   <= {AW{1'b0}};
      set_empty_q <= 1'b0;
      null_seen_q <= 1'b0;
      asm_full_q  <= 1'b0;
      asm_data_q  <= {DW{1'b0}};
      asm_pkt_q   <= 16'h0000;
      asm_wid_q   <= 16'h0000;
      asm_gen_q   <= 32'h0000_0000;
      asm_gend_q  <= 1'b0;
      asm_wend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {DW{1'b0}};
      out_pkt_q   <= 16'h0000;
      out_wid_q   <= 16'h0000;
      out_gen_q   <= 32'h0000_0000;
      out_gend_q  <= 1'b0;
      out_wend_q  <= 1'b0;
`ifdef WORD_GEN_READER_LEN_OUT_EN
      asm_len_q   <= {LW{1'b0}};
      out_len_q   <= {LW{1'b0}};
`endif
    end else begin
      rd_addr_q   <= rd_addr_d;
      set_empty_q <= set_empty_d;
      null_seen_q <= null_seen_d;
      asm_full_q  <= asm_full_d;
      asm_data_q  <= asm_data_d;
      asm_pkt_q   <= asm_pkt_d;
      asm_wid_q   <= asm_wid_d;
      asm_gen_q   <= asm_gen_d;
      asm_gend_q  <= asm_gend_d;
      asm_wend_q  <= asm_wend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_pkt_q   <= out_pkt_d;
      out_wid_q   <= out_wid_d;
      out_gen_q   <= out_gen_d;
      out_gend_q  <= out_gend_d;
      out_wend_q  <= out_wend_d;
`ifdef WORD_GEN_READER_LEN_OUT_EN
      asm_len_q   <= asm_len_d;
      out_len_q   <= out_len_d;
`endif
    end
  end

  assign rd_addr          = rd_addr_q;
  assign set_empty        = set_empty_q;
  assign out_if.dout      = out_data_q;
  assign out_if.pkt_id    = out_pkt_q;
  assign out_if.word_id   = out_wid_q;
  assign out_if.gen_id    = out_gen_q;
  assign out_if.gen_end   = out_gend_q;
  assign out_if.word_end  = out_wend_q;
  assign out_if.out_valid = out_valid_q;
`ifdef WORD_GEN_READER_LEN_OUT_EN
  assign out_if.word_len  = out_len_q;
`endif

endmodule
